// File: rtl/truth_table_sweep_ctrl.sv
// rtl/truth_table_sweep_ctrl.sv - steps a 3-input circuit through all 8 rows and checks its truth table
// Optional glitch detection per row is enabled with TRUTH_TABLE_SWEEP_GLITCH_EN.
module truth_table_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] observed,
    output logic       match,
    output logic [7:0] mismatch_mask
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
    ,
    output logic [7:0] unstable
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [2:0]       row_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       exp_q;
    logic [7:0]       obs_q;
    logic [7:0]       obs_d;
    logic [7:0]       mask_q;
    logic             match_q;
    logic [2:0]       in_q;
    logic             busy_q;
    logic             done_q;
    logic             last_cnt;
    logic             start_acc;
    logic             rows_clean;

    assign last_cnt  = (cnt_q == CNT_LAST);
    assign start_acc = (state_q == ST_IDLE) && start;

    // Table bit [7-row] holds the sample for that row, so row 000 lands in the MSB.
    always_comb begin
        obs_d = obs_q;
        obs_d[3'd7 - row_q] = dut_out;
    end

`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
    logic [7:0] unst_q;
    logic [7:0] unst_d;
    logic       prev_q;

    // The first cycle of a row has no same-row predecessor, so it is never compared.
    always_comb begin
        unst_d = unst_q;
        if ((cnt_q != '0) && (dut_out != prev_q)) begin
            unst_d[3'd7 - row_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unst_q <= 8'h00;
            prev_q <= 1'b0;
        end else if (start_acc) begin
            unst_q <= 8'h00;
        end else if ((state_q == ST_SETTLE) && !abort) begin
            unst_q <= unst_d;
            prev_q <= dut_out;
        end
    end

    assign unstable   = unst_q;
    assign rows_clean = (unst_d == 8'h00);
`else
    assign rows_clean = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            exp_q   <= 8'h00;
            obs_q   <= 8'h00;
            mask_q  <= 8'h00;
            match_q <= 1'b0;
            in_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    in_q   <= 3'd0;
                    if (start) begin
                        exp_q   <= expected;
                        row_q   <= 3'd0;
                        cnt_q   <= '0;
                        obs_q   <= 8'h00;
                        mask_q  <= 8'h00;
                        match_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        in_q    <= 3'd0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (last_cnt) begin
                        cnt_q <= '0;
                        obs_q <= obs_d;
                        if (row_q == 3'd7) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            in_q    <= 3'd0;
                            mask_q  <= obs_d ^ exp_q;
                            match_q <= (obs_d == exp_q) && rows_clean;
                            state_q <= ST_DONE;
                        end else begin
                            row_q <= row_q + 3'd1;
                            in_q  <= row_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    in_q    <= 3'd0;
                end
            endcase
        end
    end

    assign in1           = in_q[2];
    assign in2           = in_q[1];
    assign in3           = in_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign observed      = obs_q;
    assign match         = match_q;
    assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// tb/tb_truth_table_sweep_ctrl.sv - randomized self-checking bench for truth_table_sweep_ctrl
module tb_truth_table_sweep_ctrl;

    localparam int S = 4;
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic       in1, in2, in3;
    logic       busy, done, match;
    logic [7:0] observed, mismatch_mask;
    logic [7:0] func;
    logic       glitch;
    logic [2:0] row_idx;
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
    logic [7:0] unstable;
`endif

    int vectors = 0;
    int errors  = 0;

    truth_table_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .expected      (expected),
        .dut_out       (dut_out),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .busy          (busy),
        .done          (done),
        .observed      (observed),
        .match         (match),
        .mismatch_mask (mismatch_mask)
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
        ,
        .unstable      (unstable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit under control: a truth-table lookup, row 000 in the MSB, optionally glitched.
    assign row_idx = {in1, in2, in3};
    assign dut_out = func[3'd7 - row_idx] ^ glitch;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_row"}, 32'(row_idx), 32'd0);
        check({tag, "_obs"}, 32'(observed), 32'd0);
        check({tag, "_match"}, 32'(match), 32'd0);
        check({tag, "_mask"}, 32'(mismatch_mask), 32'd0);
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
        check({tag, "_unst"}, 32'(unstable), 32'd0);
`endif
    endtask

    // One sweep; negative cycle arguments disable the stray start, abort or reset event.
    task automatic sweep(input logic [7:0] f, input logic [7:0] e, input int glitch_row,
                         input int stray_cyc, input int abort_cyc, input int reset_cyc);
        logic [7:0] exp_obs;
        logic [7:0] exp_unst;
        logic       exp_match;
        int         n_rows;
        @(negedge clk);
        func     = f;
        expected = e;
        start    = 1'b1;
        abort    = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        expected = 8'($urandom);
        for (int i = 0; i < 8 * S; i++) begin
            check("busy_hi", 32'(busy), 32'd1);
            check("row", 32'(row_idx), 32'(i / S));
            check("done_lo", 32'(done), 32'd0);
            start = (i == stray_cyc);
            if (i == stray_cyc) expected = 8'hFF;
            glitch = (glitch_row == i / S) && (i % S == 1);
            if (i == abort_cyc) begin
                glitch = 1'b0;
                abort  = 1'b1;
                @(negedge clk);
                abort  = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_row", 32'(row_idx), 32'd0);
                n_rows  = i / S;
                exp_obs = f & ~(8'hFF >> n_rows);
                for (int k = 0; k < 2 * S; k++) begin
                    check("abort_nodone", 32'(done), 32'd0);
                    @(negedge clk);
                end
                check("abort_obs", 32'(observed), 32'(exp_obs));
                check("abort_match", 32'(match), 32'd0);
                return;
            end
            if (i == reset_cyc) begin
                glitch = 1'b0;
                rst_n  = 1'b0;
                #1;
                check_zero_outputs("midrst");
                @(negedge clk);
                check_zero_outputs("midrst_hold");
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        glitch    = 1'b0;
        start     = 1'b0;
        exp_unst  = (glitch_row >= 0) ? (8'h80 >> glitch_row) : 8'h00;
        exp_match = (f == e) && !(GLITCH_EN && (exp_unst != 8'h00));
        check("done_hi", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_row", 32'(row_idx), 32'd0);
        check("observed", 32'(observed), 32'(f));
        check("mask", 32'(mismatch_mask), 32'(f ^ e));
        check("match", 32'(match), 32'(exp_match));
`ifdef TRUTH_TABLE_SWEEP_GLITCH_EN
        check("unstable", 32'(unstable), 32'(exp_unst));
`endif
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("obs_hold", 32'(observed), 32'(f));
        check("match_hold", 32'(match), 32'(exp_match));
    endtask

    initial begin
        logic [7:0] rf;
        logic [7:0] re;
        int         grow;
        int         acyc;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'h00;
        func     = 8'h00;
        glitch   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_outputs("idle");

        sweep(8'h47, 8'h47, -1, -1, -1, -1);
        sweep(8'h47, 8'h46, -1, -1, -1, -1);
        sweep(8'h47, 8'h47, -1, -1, 13, -1);
        sweep(8'h47, 8'h47, -1, 10, -1, -1);
        sweep(8'h47, 8'h47, -1, -1, -1, 21);
        sweep(8'h47, 8'h47, -1, -1, -1, -1);
        sweep(8'h47, 8'h47, 2, -1, -1, -1);

        for (int t = 0; t < 10; t++) begin
            rf   = 8'($urandom);
            re   = ($urandom_range(0, 1) == 0) ? rf : (rf ^ 8'($urandom_range(1, 255)));
            grow = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            acyc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8 * S - 1)) : -1;
            sweep(rf, re, grow, -1, acyc, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
